// File: rtl/tp_adc_pkg.sv
// Shared types and command-byte field positions for the touch-panel ADC responder.
package tp_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT,
    BUSYST,
    DATA
  } state_t;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SHORT_BITS = 8;

  // Command byte layout: {S, A2, A1, A0, MODE, SER/DFR, PD1, PD0}
  localparam int unsigned CMD_S_BIT    = 7;
  localparam int unsigned CMD_A_HI     = 6;
  localparam int unsigned CMD_A_LO     = 4;
  localparam int unsigned CMD_MODE_BIT = 3;
  localparam int unsigned CMD_SER_BIT  = 2;
  localparam int unsigned CMD_PD1_BIT  = 1;
  localparam int unsigned CMD_PD0_BIT  = 0;

  localparam logic [2:0] CH_X = 3'b001;
  localparam logic [2:0] CH_Y = 3'b101;

  function automatic logic [2:0] cmd_channel(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_A_HI:CMD_A_LO];
  endfunction

  function automatic logic cmd_is_short(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_MODE_BIT];
  endfunction

endpackage

// File: rtl/tp_adc_responder_if.sv
// Touch-panel SPI pin bundle; master is the panel controller, slave is the ADC.
interface tp_adc_responder_if;

  logic TP_DCLK_I;
  logic TP_DIN_I;
  logic TP_SS_N_I;
  logic TP_DOUT_O;
  logic TP_BUSY_O;
  logic TP_PENIRQ_N_O;

  modport master (
    output TP_DCLK_I,
    output TP_DIN_I,
    output TP_SS_N_I,
    input  TP_DOUT_O,
    input  TP_BUSY_O,
    input  TP_PENIRQ_N_O
  );

  modport slave (
    input  TP_DCLK_I,
    input  TP_DIN_I,
    input  TP_SS_N_I,
    output TP_DOUT_O,
    output TP_BUSY_O,
    output TP_PENIRQ_N_O
  );

endinterface

// File: rtl/tp_sync_edge.sv
// Multi-flop synchronizer: one channel with registered rise/fall pulses, plus level-only channels.
module tp_sync_edge #(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       LVL_W       = 1,
  parameter logic [LVL_W-1:0]  LVL_RST     = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             edge_in,
  input  logic [LVL_W-1:0] lvl_in,
  output logic [LVL_W-1:0] lvl,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] edge_q;
  logic [LVL_W-1:0]       lvl_q [SYNC_STAGES];

  // Pulses are taken one stage early so they line up with the synchronized levels.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      edge_q <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) lvl_q[i] <= LVL_RST;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      edge_q   <= {edge_q[SYNC_STAGES-2:0], edge_in};
      lvl_q[0] <= lvl_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) lvl_q[i] <= lvl_q[i-1];
      rise     <=  edge_q[SYNC_STAGES-2] & ~edge_q[SYNC_STAGES-1];
      fall     <= ~edge_q[SYNC_STAGES-2] &  edge_q[SYNC_STAGES-1];
    end
  end

  assign lvl = lvl_q[SYNC_STAGES-1];

endmodule

// File: rtl/tp_adc_responder.sv
// ADS7843-style SPI responder: captures command bytes and returns programmable X/Y samples.
module tp_adc_responder
  import tp_adc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CONV_BITS   = 12
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  tp_adc_responder_if.slave    tp,
  input  logic                 Touch_I,
  input  logic [CONV_BITS-1:0] X_value_I,
  input  logic [CONV_BITS-1:0] Y_value_I,
  output logic                 Cmd_valid_O,
  output logic [CMD_W-1:0]     Last_cmd_O
);

  localparam int unsigned LVL_W = 2;

  logic [LVL_W-1:0] pin_lvl;
  logic             din_s;
  logic             ss_n_s;
  logic             dclk_rise;
  logic             dclk_fall;

  tp_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .LVL_W       (LVL_W),
    .LVL_RST     (2'b10)
  ) u_sync (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .edge_in (tp.TP_DCLK_I),
    .lvl_in  ({tp.TP_SS_N_I, tp.TP_DIN_I}),
    .lvl     (pin_lvl),
    .rise    (dclk_rise),
    .fall    (dclk_fall)
  );

  assign din_s  = pin_lvl[0];
  assign ss_n_s = pin_lvl[1];

  state_t               state_q, state_d;
  logic [CMD_W-2:0]     cmd_sr_q, cmd_sr_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CONV_BITS-1:0] res_sr_q, res_sr_d;
  logic                 short_q, short_d;
  logic                 dout_q, dout_d;
  logic                 busy_q, busy_d;
  logic                 pen_n_q, pen_n_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]     last_cmd_q, last_cmd_d;
  logic [CMD_W-1:0]     new_cmd;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      cmd_sr_q    <= '0;
      bit_cnt_q   <= '0;
      res_sr_q    <= '0;
      short_q     <= 1'b0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      pen_n_q     <= 1'b1;
      cmd_valid_q <= 1'b0;
      last_cmd_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_sr_q    <= cmd_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      res_sr_q    <= res_sr_d;
      short_q     <= short_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      pen_n_q     <= pen_n_d;
      cmd_valid_q <= cmd_valid_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_sr_d    = cmd_sr_q;
    bit_cnt_d   = bit_cnt_q;
    res_sr_d    = res_sr_q;
    short_d     = short_q;
    dout_d      = 1'b0;
    cmd_valid_d = 1'b0;
    last_cmd_d  = last_cmd_q;
    new_cmd     = {cmd_sr_q, din_s};

    // Deselect overrides any DCLK edge seen in the same cycle.
    if (ss_n_s) begin
      state_d   = IDLE;
      cmd_sr_d  = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CMD;
          cmd_sr_d  = '0;
          bit_cnt_d = '0;
        end
        CMD: begin
          // Leading zeros are discarded until the start bit arrives.
          if (dclk_rise && (bit_cnt_q != '0 || din_s)) begin
            if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
              state_d     = WAIT;
              cmd_sr_d    = '0;
              bit_cnt_d   = '0;
              cmd_valid_d = 1'b1;
              last_cmd_d  = new_cmd;
              short_d     = cmd_is_short(new_cmd);
              unique case (cmd_channel(new_cmd))
                CH_X:    res_sr_d = X_value_I;
                CH_Y:    res_sr_d = Y_value_I;
                default: res_sr_d = '0;
              endcase
            end else begin
              cmd_sr_d  = new_cmd[CMD_W-2:0];
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (dclk_fall) state_d = BUSYST;
        end
        BUSYST: begin
          if (dclk_fall) begin
            state_d   = DATA;
            dout_d    = res_sr_q[CONV_BITS-1];
            res_sr_d  = {res_sr_q[CONV_BITS-2:0], 1'b0};
            bit_cnt_d = short_q ? CNT_W'(SHORT_BITS - 1) : CNT_W'(CONV_BITS - 1);
          end
        end
        DATA: begin
          dout_d = dout_q;
          if (dclk_fall) begin
            if (bit_cnt_q == '0) begin
              state_d = CMD;
              dout_d  = 1'b0;
            end else begin
              dout_d    = res_sr_q[CONV_BITS-1];
              res_sr_d  = {res_sr_q[CONV_BITS-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d  = (state_d == BUSYST);
    // Pen interrupt only reported while no transfer is in progress.
    pen_n_d = (state_d == IDLE) ? ~Touch_I : 1'b1;
  end

  assign tp.TP_DOUT_O     = dout_q;
  assign tp.TP_BUSY_O     = busy_q;
  assign tp.TP_PENIRQ_N_O = pen_n_q;
  assign Cmd_valid_O      = cmd_valid_q;
  assign Last_cmd_O       = last_cmd_q;

endmodule

// File: tb/tb_tp_adc_responder.sv
// Bench for tp_adc_responder: drives SPI frames and compares against a frame-level response model.
module tb_tp_adc_responder;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Touch_I;
  logic [11:0] X_value_I;
  logic [11:0] Y_value_I;
  logic        Cmd_valid_O;
  logic [7:0]  Last_cmd_O;

  int checks = 0;
  int errors = 0;
  int cv_count = 0;
  int cv_start;

  logic [31:0] obs_dout, obs_brise, obs_bfall;
  logic        obs_pen;

  tp_adc_responder_if tp_if ();

  tp_adc_responder dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .tp          (tp_if),
    .Touch_I     (Touch_I),
    .X_value_I   (X_value_I),
    .Y_value_I   (Y_value_I),
    .Cmd_valid_O (Cmd_valid_O),
    .Last_cmd_O  (Last_cmd_O)
  );

  always #10 Clock = ~Clock;

  always @(negedge Clock) if (Cmd_valid_O === 1'b1) cv_count = cv_count + 1;

  // Expected DOUT seen at DCLK rise r: start bit on rise pre+1, data from rise pre+10.
  function automatic logic exp_dout_at(input logic [7:0] cmd, input int pre, input int r,
                                       input logic [11:0] x, input logic [11:0] y);
    logic [11:0] v;
    int n;
    int first;
    if (cmd[6:4] == 3'b001)      v = x;
    else if (cmd[6:4] == 3'b101) v = y;
    else                         v = 12'h000;
    n = cmd[3] ? 8 : 12;
    first = pre + 10;
    if (r >= first && r < first + n) return v[11 - (r - first)];
    return 1'b0;
  endfunction

  task automatic run_frame(input logic [7:0] cmd, input int pre, input int ndclk,
                           input int chg_rise, input logic [11:0] chg_x);
    logic [7:0] c;
    c = cmd;
    obs_dout = '0; obs_brise = '0; obs_bfall = '0; obs_pen = 1'b1;
    cv_start = cv_count;
    @(negedge Clock);
    tp_if.TP_SS_N_I = 1'b0;
    #500;
    for (int r = 1; r <= ndclk; r++) begin
      tp_if.TP_DIN_I = (r > pre && r <= pre + 8) ? c[7 - (r - pre - 1)] : 1'b0;
      #500;
      obs_dout[r]  = tp_if.TP_DOUT_O;
      obs_brise[r] = tp_if.TP_BUSY_O;
      obs_pen      = obs_pen & tp_if.TP_PENIRQ_N_O;
      if (r == chg_rise) X_value_I = chg_x;
      tp_if.TP_DCLK_I = 1'b1;
      #500;
      obs_bfall[r] = tp_if.TP_BUSY_O;
      tp_if.TP_DCLK_I = 1'b0;
    end
    tp_if.TP_DIN_I = 1'b0;
    #500;
  endtask

  task automatic end_frame();
    tp_if.TP_SS_N_I = 1'b1;
    repeat (10) @(negedge Clock);
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Touch_I = 1'b1;
    X_value_I = '0; Y_value_I = '0;
    tp_if.TP_DCLK_I = 1'b0; tp_if.TP_DIN_I = 1'b0; tp_if.TP_SS_N_I = 1'b1;
    repeat (5) @(negedge Clock);
    checks++;
    if ({tp_if.TP_DOUT_O, tp_if.TP_BUSY_O, tp_if.TP_PENIRQ_N_O, Cmd_valid_O} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outputs: dout/busy/penirq_n/cmd_valid got %b required 0010",
               {tp_if.TP_DOUT_O, tp_if.TP_BUSY_O, tp_if.TP_PENIRQ_N_O, Cmd_valid_O});
    end
    checks++;
    if (Last_cmd_O !== 8'h00) begin
      errors++;
      $display("FAIL reset_last_cmd: got %h required 00", Last_cmd_O);
    end
  endtask

  task automatic test_idle_touch();
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (tp_if.TP_PENIRQ_N_O !== 1'b0) begin
      errors++;
      $display("FAIL idle_touch_penirq: got %b required 0", tp_if.TP_PENIRQ_N_O);
    end
    Touch_I = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (tp_if.TP_PENIRQ_N_O !== 1'b1) begin
      errors++;
      $display("FAIL idle_untouched_penirq: got %b required 1", tp_if.TP_PENIRQ_N_O);
    end
    Touch_I = 1'b1;
    repeat (2) @(negedge Clock);
    tp_if.TP_SS_N_I = 1'b0;
    repeat (4) @(negedge Clock);
    checks++;
    if (tp_if.TP_PENIRQ_N_O !== 1'b1) begin
      errors++;
      $display("FAIL selected_penirq: got %b required 1", tp_if.TP_PENIRQ_N_O);
    end
    end_frame();
  endtask

  task automatic test_frames();
    logic [7:0] cmds [6] = '{8'h90, 8'hD0, 8'hD8, 8'h80, 8'h90, 8'h90};
    int         pres [6] = '{0, 0, 0, 0, 3, 0};
    int         chgs [6] = '{0, 0, 0, 0, 0, 12};
    logic [31:0] exp_d, exp_b;
    for (int f = 0; f < 6; f++) begin
      X_value_I = 12'hA5C; Y_value_I = 12'h3F1;
      run_frame(cmds[f], pres[f], pres[f] + 24, chgs[f], 12'h123);
      exp_d = '0; exp_b = '0;
      for (int r = 1; r <= pres[f] + 24; r++)
        exp_d[r] = exp_dout_at(cmds[f], pres[f], r, 12'hA5C, 12'h3F1);
      exp_b[pres[f] + 9] = 1'b1;
      checks++;
      if (obs_dout !== exp_d) begin
        errors++;
        $display("FAIL frame%0d_dout: got %h required %h", f, obs_dout, exp_d);
      end
      checks++;
      if (obs_brise !== exp_b || obs_bfall !== exp_b) begin
        errors++;
        $display("FAIL frame%0d_busy: rise %h fall %h required %h", f, obs_brise, obs_bfall, exp_b);
      end
      checks++;
      if (cv_count - cv_start !== 1 || Last_cmd_O !== cmds[f]) begin
        errors++;
        $display("FAIL frame%0d_cmd: pulses %0d last %h required 1 and %h",
                 f, cv_count - cv_start, Last_cmd_O, cmds[f]);
      end
      checks++;
      if (obs_pen !== 1'b1) begin
        errors++;
        $display("FAIL frame%0d_penirq: got %b required 1", f, obs_pen);
      end
      end_frame();
    end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [2:0]  ch;
    logic [11:0] x0, y0;
    logic [31:0] exp_d, exp_b;
    int pre, chg;
    for (int f = 0; f < 12; f++) begin
      x0 = 12'($urandom); y0 = 12'($urandom);
      case ($urandom_range(0, 2))
        0:       ch = 3'b001;
        1:       ch = 3'b101;
        default: ch = 3'($urandom);
      endcase
      cmd = {1'b1, ch, 1'($urandom), 3'($urandom)};
      pre = $urandom_range(0, 3);
      chg = ($urandom_range(0, 1) == 1) ? pre + 9 + $urandom_range(0, 10) : 0;
      X_value_I = x0; Y_value_I = y0;
      run_frame(cmd, pre, pre + 24, chg, 12'($urandom));
      exp_d = '0; exp_b = '0;
      for (int r = 1; r <= pre + 24; r++) exp_d[r] = exp_dout_at(cmd, pre, r, x0, y0);
      exp_b[pre + 9] = 1'b1;
      checks++;
      if (obs_dout !== exp_d) begin
        errors++;
        $display("FAIL rand%0d_dout: cmd %h got %h required %h", f, cmd, obs_dout, exp_d);
      end
      checks++;
      if (obs_brise !== exp_b || obs_bfall !== exp_b) begin
        errors++;
        $display("FAIL rand%0d_busy: rise %h fall %h required %h", f, obs_brise, obs_bfall, exp_b);
      end
      checks++;
      if (cv_count - cv_start !== 1 || Last_cmd_O !== cmd) begin
        errors++;
        $display("FAIL rand%0d_cmd: pulses %0d last %h required 1 and %h",
                 f, cv_count - cv_start, Last_cmd_O, cmd);
      end
      end_frame();
    end
  endtask

  task automatic test_abort();
    logic [31:0] exp_d;
    Y_value_I = 12'h3F1;
    run_frame(8'hD0, 0, 14, 0, 12'h000);
    checks++;
    if (tp_if.TP_DOUT_O !== exp_dout_at(8'hD0, 0, 15, X_value_I, 12'h3F1)) begin
      errors++;
      $display("FAIL abort_pre_dout: got %b required %b", tp_if.TP_DOUT_O,
               exp_dout_at(8'hD0, 0, 15, X_value_I, 12'h3F1));
    end
    @(negedge Clock);
    tp_if.TP_SS_N_I = 1'b1;
    repeat (3) @(negedge Clock);
    checks++;
    if (tp_if.TP_DOUT_O !== 1'b0 || tp_if.TP_BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: dout %b busy %b required 0 0", tp_if.TP_DOUT_O, tp_if.TP_BUSY_O);
    end
    repeat (10) @(negedge Clock);
    run_frame(8'hD0, 0, 24, 0, 12'h000);
    exp_d = '0;
    for (int r = 1; r <= 24; r++) exp_d[r] = exp_dout_at(8'hD0, 0, r, X_value_I, 12'h3F1);
    checks++;
    if (obs_dout !== exp_d) begin
      errors++;
      $display("FAIL abort_next_frame_dout: got %h required %h", obs_dout, exp_d);
    end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_idle_touch();
    test_frames();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
